phase_shift_amp_mult: RTL and testbench

- Downstream consumer of the controlled-phase-shift cos/sin ROM pair (real and imaginary, DATA_WIDTH wide, 1-cycle registered read).
- Applies R(k) = diag(1, e^(i*2*pi/2^k)) to one complex amplitude of the |1> branch: drives the ROM address and multiplies the amplitude by the fetched phase factor.
- Returns the rotated amplitude over a valid/ready handshake.
- Sits between the nonstabilizer-gate controller (amplitude source) and the amplitude write-back stage.

---
 rtl/phase_shift_amp_mult_if.sv | 28 ++
 rtl/phase_shift_amp_mult.sv | 133 +++++++++++++
 tb/tb_phase_shift_amp_mult.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_shift_amp_mult_if.sv
// Valid/ready amplitude bus for phase_shift_amp_mult. It carries the input side
// (amplitude, rotation index k, conj) and the output side (rotated amplitude, error flag).
interface phase_shift_amp_mult_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 5
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [ADDR_WIDTH:0]          in_k;
    logic                         in_conj;
    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_re;
    logic signed [DATA_WIDTH-1:0] out_im;
    logic                         out_err;

    modport master (
        output in_valid, in_k, in_conj, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_err
    );

    modport slave (
        input  in_valid, in_k, in_conj, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_err
    );
endinterface

// File: rtl/phase_shift_amp_mult.sv
// Applies R(k) = diag(1, e^(i*2*pi/2^k)) to one |1>-branch amplitude using the cos/sin phase ROMs.
// Optional macro PHASE_SHIFT_ROUND_EN: round half up before the fixed-point shift (default truncates).
module phase_shift_amp_mult #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 5,
    parameter int FRAC_BITS  = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    phase_shift_amp_mult_if.slave        bus,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_re_q,
    input  logic signed [DATA_WIDTH-1:0] rom_im_q
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = 2 * DATA_WIDTH + 1;
    localparam int KW = ADDR_WIDTH + 1;

    localparam logic signed [SW-1:0] SatMax = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MostPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [KW-1:0]         KLimit  = KW'(2 + 2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {StIdle, StFetch, StMul, StSum, StOut} state_e;

    state_e                       state;
    logic signed [DATA_WIDTH-1:0] re_q, im_q;
    logic [KW-1:0]                k_q;
    logic                         conj_q;
    logic signed [PW-1:0]         p_rc, p_is, p_rs, p_ic;

    logic [KW-1:0]                k_off;
    logic signed [SW-1:0]         sum_re, sum_im;
    logic [DATA_WIDTH-1:0]        res_re, res_im;
    logic                         res_err;

    function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] y;
`ifdef PHASE_SHIFT_ROUND_EN
        y = x + (SW'(1) <<< (FRAC_BITS - 1));
`else
        y = x;
`endif
        y = y >>> FRAC_BITS;
        if (y > SatMax) return MostPos;
        if (y < SatMin) return MostNeg;
        return y[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
        return (x == MostNeg) ? MostPos : -x;
    endfunction

    // Conjugation flips the sign of s, folded into add/sub so s itself is never negated.
    always_comb begin
        k_off   = bus.in_k - KW'(2);
        sum_re  = conj_q ? SW'(p_rc) + SW'(p_is) : SW'(p_rc) - SW'(p_is);
        sum_im  = conj_q ? SW'(p_ic) - SW'(p_rs) : SW'(p_ic) + SW'(p_rs);
        res_err = 1'b0;
        res_re  = scale_sat(sum_re);
        res_im  = scale_sat(sum_im);
        if (k_q == KW'(0)) begin
            res_re = re_q;
            res_im = im_q;
        end else if (k_q == KW'(1)) begin
            res_re = neg_sat(re_q);
            res_im = neg_sat(im_q);
        end else if (k_q >= KLimit) begin
            res_re  = re_q;
            res_im  = im_q;
            res_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            rom_addr      <= '0;
            re_q          <= '0;
            im_q          <= '0;
            k_q           <= '0;
            conj_q        <= 1'b0;
            p_rc          <= '0;
            p_is          <= '0;
            p_rs          <= '0;
            p_ic          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        re_q         <= bus.in_re;
                        im_q         <= bus.in_im;
                        k_q          <= bus.in_k;
                        conj_q       <= bus.in_conj;
                        rom_addr     <= k_off[ADDR_WIDTH-1:0];
                        bus.out_err  <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= StFetch;
                    end
                end
                StFetch: state <= StMul;
                StMul: begin
                    p_rc  <= PW'(re_q) * PW'(rom_re_q);
                    p_is  <= PW'(im_q) * PW'(rom_im_q);
                    p_rs  <= PW'(re_q) * PW'(rom_im_q);
                    p_ic  <= PW'(im_q) * PW'(rom_re_q);
                    state <= StSum;
                end
                StSum: begin
                    bus.out_re    <= res_re;
                    bus.out_im    <= res_im;
                    bus.out_err   <= res_err;
                    bus.out_valid <= 1'b1;
                    state         <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_shift_amp_mult.sv
// Randomized self-checking bench for phase_shift_amp_mult against a complex-arithmetic model.
// Honours PHASE_SHIFT_ROUND_EN in the model and the directed rounding expectations.
module tb_phase_shift_amp_mult;
    localparam int DW = 24;
    localparam int AW = 5;
    localparam int FB = 22;
`ifdef PHASE_SHIFT_ROUND_EN
    localparam logic [DW-1:0] RndOne = 24'd1;
`else
    localparam logic [DW-1:0] RndOne = 24'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        rom_addr;
    logic signed [DW-1:0] rom_re_q, rom_im_q;
    logic signed [DW-1:0] cos_rom [2**AW];
    logic signed [DW-1:0] sin_rom [2**AW];
    int                   n_checks = 0;
    int                   n_errors = 0;

    always #5 clk = ~clk;

    phase_shift_amp_mult_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    phase_shift_amp_mult #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAC_BITS(FB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_re_q (rom_re_q),
        .rom_im_q (rom_im_q)
    );

    always @(posedge clk) begin
        rom_re_q <= cos_rom[rom_addr];
        rom_im_q <= sin_rom[rom_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_model(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        if (v > hi) return hi[DW-1:0];
        if (v < lo) return lo[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic longint scale(input longint v);
        longint t;
        t = v;
`ifdef PHASE_SHIFT_ROUND_EN
        t = t + (longint'(1) <<< (FB - 1));
`endif
        return t >>> FB;
    endfunction

    // (re + i*im) * (c + i*s'), s' = -s for the inverse rotation
    function automatic void model(input int k, input bit conj, input logic signed [DW-1:0] re,
                                  input logic signed [DW-1:0] im, output logic [DW-1:0] ore,
                                  output logic [DW-1:0] oim, output bit err);
        longint r, i, c, s;
        r = re;
        i = im;
        err = 1'b0;
        if (k == 0) begin
            ore = re;
            oim = im;
        end else if (k == 1) begin
            ore = sat_model(-r);
            oim = sat_model(-i);
        end else if (k >= 2 + 2 ** AW) begin
            ore = re;
            oim = im;
            err = 1'b1;
        end else begin
            c = cos_rom[k-2];
            s = sin_rom[k-2];
            if (conj) s = -s;
            ore = sat_model(scale(r * c - i * s));
            oim = sat_model(scale(r * s + i * c));
        end
    endfunction

    task automatic run(input string tag, input int k, input bit conj,
                       input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                       input int hold, input logic [DW-1:0] exp_re,
                       input logic [DW-1:0] exp_im, input bit exp_err);
        int lat;
        int bad;
        @(negedge clk);
        check({tag, "/in_ready_idle"}, DW'(bus.in_ready), 1);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_k      = k[AW:0];
        bus.in_conj   = conj;
        bus.in_re     = re;
        bus.in_im     = im;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_re    = DW'($urandom);
        bus.in_im    = DW'($urandom);
        @(negedge clk);
        check({tag, "/rom_addr"}, DW'(rom_addr), DW'((k - 2) & (2 ** AW - 1)));
        check({tag, "/in_ready_busy"}, DW'(bus.in_ready), 0);
        // lat counts negedges after the accept edge; FETCH, MUL, SUM precede OUT
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, DW'(lat), 4);
        if (bus.out_valid) begin
            check({tag, "/out_re"}, bus.out_re, exp_re);
            check({tag, "/out_im"}, bus.out_im, exp_im);
            check({tag, "/out_err"}, DW'(bus.out_err), DW'(exp_err));
        end
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_k     = 6'd0;
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_re !== exp_re ||
                bus.out_im !== exp_im || bus.out_err !== exp_err) bad++;
        end
        if (hold > 0) check({tag, "/hold_stable"}, DW'(bad), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/valid_drop"}, DW'(bus.out_valid), 0);
        check({tag, "/ready_back"}, DW'(bus.in_ready), 1);
    endtask

    initial begin
        logic [DW-1:0]        e_re, e_im;
        bit                   e_err;
        int                   k, hold, stale;
        bit                   conj;
        logic signed [DW-1:0] re, im;

        for (int a = 0; a < 2 ** AW; a++) begin
            cos_rom[a] = DW'($urandom);
            sin_rom[a] = DW'($urandom);
        end
        cos_rom[0] = 24'h000000; sin_rom[0] = 24'h400000;
        cos_rom[1] = 24'h2D413C; sin_rom[1] = 24'h000000;
        cos_rom[2] = 24'h200000; sin_rom[2] = 24'h000000;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_k      = '0;
        bus.in_conj   = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst/in_ready", DW'(bus.in_ready), 1);
        check("rst/out_valid", DW'(bus.out_valid), 0);
        check("rst/out_err", DW'(bus.out_err), 0);
        check("rst/rom_addr", DW'(rom_addr), 0);
        check("rst/out_re", bus.out_re, 0);
        check("rst/out_im", bus.out_im, 0);
        rst = 1'b0;

        run("k2", 2, 1'b0, 24'h400000, 24'h000000, 0, 24'h000000, 24'h400000, 1'b0);
        run("k2conj", 2, 1'b1, 24'h400000, 24'h000000, 0, 24'h000000, 24'hC00000, 1'b0);
        run("k1", 1, 1'b0, 24'h100000, 24'h200000, 0, 24'hF00000, 24'hE00000, 1'b0);
        run("k1sat", 1, 1'b1, 24'h800000, 24'h000000, 0, 24'h7FFFFF, 24'h000000, 1'b0);
        run("k35", 35, 1'b0, 24'h123456, 24'h0ABCDE, 0, 24'h123456, 24'h0ABCDE, 1'b1);
        run("k3_three", 3, 1'b0, 24'h000003, 24'h000000, 0, 24'h000002, 24'h000000, 1'b0);
        // 0.707 LSB: truncates to 0, rounds up to 1
        run("k3_one", 3, 1'b0, 24'h000001, 24'h000000, 0, RndOne, 24'h000000, 1'b0);
        run("half", 4, 1'b0, 24'h000001, 24'h000000, 0, RndOne, 24'h000000, 1'b0);
        run("k0", 0, 1'b1, 24'h7654AB, 24'h80000F, 0, 24'h7654AB, 24'h80000F, 1'b0);
        run("bp", 2, 1'b0, 24'h400000, 24'h000000, 10, 24'h000000, 24'h400000, 1'b0);

        // asynchronous reset while the transaction sits in MUL
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_k     = 6'd2;
        bus.in_re    = 24'h400000;
        bus.in_im    = 24'h000000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst/out_valid", DW'(bus.out_valid), 0);
        check("arst/in_ready", DW'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        check("arst/no_stale", DW'(stale), 0);
        check("arst/ready_idle", DW'(bus.in_ready), 1);

        for (int n = 0; n < 60; n++) begin
            k    = $urandom_range(0, 40);
            conj = 1'($urandom);
            re   = ($urandom_range(0, 7) == 0) ? 24'h800000 : DW'($urandom);
            im   = ($urandom_range(0, 7) == 0) ? 24'h800000 : DW'($urandom);
            hold = $urandom_range(0, 3);
            model(k, conj, re, im, e_re, e_im, e_err);
            run($sformatf("rnd%0d_k%0d", n, k), k, conj, re, im, hold, e_re, e_im, e_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
